// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared channel state encoding and requester IDs for the DDR round-robin arbiter.
package ddr_arb_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam logic ID_DMA  = 1'b0;
    localparam logic ID_XCEL = 1'b1;
endpackage

// File: rtl/ddr_arb_channel.sv
// ddr_arb_channel: one arbitrated channel (FSM, round-robin pointer, beat counter, request/data mux).
// "up" signals travel from requesters toward the core, "down" signals travel back toward the requesters.
module ddr_arb_channel
    import ddr_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                xcel_busy,
    input  logic [1:0]          rq_valid,
    output logic [1:0]          rq_ready,
    input  logic [1:0][AW-1:0]  rq_addr,
    input  logic [1:0][31:0]    rq_len,
    input  logic [1:0][2:0]     rq_size,
    input  logic [1:0][1:0]     rq_burst,
    output logic                core_valid,
    input  logic                core_ready,
    output logic [AW-1:0]       core_addr,
    output logic [31:0]         core_len,
    output logic [2:0]          core_size,
    output logic [1:0]          core_burst,
    input  logic [1:0][DW-1:0]  up_data,
    input  logic [1:0]          up_hs,
    output logic [1:0][DW-1:0]  down_data,
    output logic [1:0]          down_hs,
    output logic [DW-1:0]       core_up_data,
    output logic                core_up_hs,
    input  logic [DW-1:0]       core_down_data,
    input  logic                core_down_hs
);
    state_t      state;
    logic        gnt;
    logic        ptr;
    logic [31:0] cnt;
    logic        in_req;
    logic        in_dat;
    logic        pick;
    logic        fire_req;
    logic        fire_dat;

    always_comb begin
        in_req       = state == ST_REQ;
        in_dat       = state == ST_DATA;
        pick         = (&rq_valid) ? (xcel_busy ? ID_XCEL : ptr) : rq_valid[ID_XCEL];
        core_valid   = in_req & rq_valid[gnt];
        core_addr    = rq_addr[gnt];
        core_len     = rq_len[gnt];
        core_size    = rq_size[gnt];
        core_burst   = rq_burst[gnt];
        rq_ready     = '0;
        rq_ready[gnt] = in_req & core_ready;
        fire_req     = core_valid & core_ready;
        core_up_hs   = in_dat & up_hs[gnt];
        core_up_data = up_data[gnt];
        down_hs      = '0;
        down_hs[gnt] = in_dat & core_down_hs;
        down_data    = '0;
        down_data[gnt] = core_down_data;
        // valid/ready pairing is symmetric, so one expression covers both directions
        fire_dat     = in_dat & up_hs[gnt] & core_down_hs;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            gnt   <= ID_DMA;
            ptr   <= ID_DMA;
            cnt   <= '0;
        end else begin
            if (state == ST_IDLE && |rq_valid) begin
                gnt   <= pick;
                state <= ST_REQ;
            end
            if (fire_req) begin
                state <= ST_DATA;
                cnt   <= core_len;
            end
            if (fire_dat) begin
                if (cnt == '0) begin
                    state <= ST_IDLE;
                    ptr   <= ~gnt;
                end else begin
                    cnt <= cnt - 32'd1;
                end
            end
        end
    end
endmodule

// File: rtl/ddr_rr_arbiter.sv
// ddr_rr_arbiter: shares one AXI adapter port between dma and xcel with independent
// round-robin read and write channels.
module ddr_rr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  xcel_busy,
    input  logic                  dma_read_request_valid,
    output logic                  dma_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] dma_read_addr,
    input  logic [31:0]           dma_read_len,
    input  logic [2:0]            dma_read_size,
    input  logic [1:0]            dma_read_burst,
    output logic [AXI_DWIDTH-1:0] dma_read_data,
    output logic                  dma_read_data_valid,
    input  logic                  dma_read_data_ready,
    input  logic                  xcel_read_request_valid,
    output logic                  xcel_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] xcel_read_addr,
    input  logic [31:0]           xcel_read_len,
    input  logic [2:0]            xcel_read_size,
    input  logic [1:0]            xcel_read_burst,
    output logic [AXI_DWIDTH-1:0] xcel_read_data,
    output logic                  xcel_read_data_valid,
    input  logic                  xcel_read_data_ready,
    input  logic                  dma_write_request_valid,
    output logic                  dma_write_request_ready,
    input  logic [AXI_AWIDTH-1:0] dma_write_addr,
    input  logic [31:0]           dma_write_len,
    input  logic [2:0]            dma_write_size,
    input  logic [1:0]            dma_write_burst,
    input  logic [AXI_DWIDTH-1:0] dma_write_data,
    input  logic                  dma_write_data_valid,
    output logic                  dma_write_data_ready,
    input  logic                  xcel_write_request_valid,
    output logic                  xcel_write_request_ready,
    input  logic [AXI_AWIDTH-1:0] xcel_write_addr,
    input  logic [31:0]           xcel_write_len,
    input  logic [2:0]            xcel_write_size,
    input  logic [1:0]            xcel_write_burst,
    input  logic [AXI_DWIDTH-1:0] xcel_write_data,
    input  logic                  xcel_write_data_valid,
    output logic                  xcel_write_data_ready,
    output logic                  core_read_request_valid,
    input  logic                  core_read_request_ready,
    output logic [AXI_AWIDTH-1:0] core_read_addr,
    output logic [31:0]           core_read_len,
    output logic [2:0]            core_read_size,
    output logic [1:0]            core_read_burst,
    input  logic [AXI_DWIDTH-1:0] core_read_data,
    input  logic                  core_read_data_valid,
    output logic                  core_read_data_ready,
    output logic                  core_write_request_valid,
    input  logic                  core_write_request_ready,
    output logic [AXI_AWIDTH-1:0] core_write_addr,
    output logic [31:0]           core_write_len,
    output logic [2:0]            core_write_size,
    output logic [1:0]            core_write_burst,
    output logic [AXI_DWIDTH-1:0] core_write_data,
    output logic                  core_write_data_valid,
    input  logic                  core_write_data_ready
);
    logic [AXI_DWIDTH-1:0]      unused_rd_up_data;
    logic [1:0][AXI_DWIDTH-1:0] unused_wr_down_data;

    ddr_arb_channel #(.AW(AXI_AWIDTH), .DW(AXI_DWIDTH)) u_rd (
        .clk            (clk),
        .resetn         (resetn),
        .xcel_busy      (xcel_busy),
        .rq_valid       ({xcel_read_request_valid, dma_read_request_valid}),
        .rq_ready       ({xcel_read_request_ready, dma_read_request_ready}),
        .rq_addr        ({xcel_read_addr, dma_read_addr}),
        .rq_len         ({xcel_read_len, dma_read_len}),
        .rq_size        ({xcel_read_size, dma_read_size}),
        .rq_burst       ({xcel_read_burst, dma_read_burst}),
        .core_valid     (core_read_request_valid),
        .core_ready     (core_read_request_ready),
        .core_addr      (core_read_addr),
        .core_len       (core_read_len),
        .core_size      (core_read_size),
        .core_burst     (core_read_burst),
        .up_data        ('0),
        .up_hs          ({xcel_read_data_ready, dma_read_data_ready}),
        .down_data      ({xcel_read_data, dma_read_data}),
        .down_hs        ({xcel_read_data_valid, dma_read_data_valid}),
        .core_up_data   (unused_rd_up_data),
        .core_up_hs     (core_read_data_ready),
        .core_down_data (core_read_data),
        .core_down_hs   (core_read_data_valid)
    );

    ddr_arb_channel #(.AW(AXI_AWIDTH), .DW(AXI_DWIDTH)) u_wr (
        .clk            (clk),
        .resetn         (resetn),
        .xcel_busy      (xcel_busy),
        .rq_valid       ({xcel_write_request_valid, dma_write_request_valid}),
        .rq_ready       ({xcel_write_request_ready, dma_write_request_ready}),
        .rq_addr        ({xcel_write_addr, dma_write_addr}),
        .rq_len         ({xcel_write_len, dma_write_len}),
        .rq_size        ({xcel_write_size, dma_write_size}),
        .rq_burst       ({xcel_write_burst, dma_write_burst}),
        .core_valid     (core_write_request_valid),
        .core_ready     (core_write_request_ready),
        .core_addr      (core_write_addr),
        .core_len       (core_write_len),
        .core_size      (core_write_size),
        .core_burst     (core_write_burst),
        .up_data        ({xcel_write_data, dma_write_data}),
        .up_hs          ({xcel_write_data_valid, dma_write_data_valid}),
        .down_data      (unused_wr_down_data),
        .down_hs        ({xcel_write_data_ready, dma_write_data_ready}),
        .core_up_data   (core_write_data),
        .core_up_hs     (core_write_data_valid),
        .core_down_data ('0),
        .core_down_hs   (core_write_data_ready)
    );
endmodule

// File: tb/tb_ddr_rr_arbiter.sv
// tb_ddr_rr_arbiter: randomized directed scenarios checked against a transaction-level
// model of grant order, request fields and per-requester beat delivery.
module tb_ddr_rr_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic xcel_busy = 1'b0;

    logic [1:0]  rqv [2];
    logic [31:0] rqa [2][2];
    logic [31:0] rql [2][2];
    logic [2:0]  rqs [2][2];
    logic [1:0]  rqb [2][2];
    logic [1:0]  crq_rdy;
    logic [1:0]  rd_rdy;
    logic        crd_v;
    logic [31:0] crd_d;
    logic [1:0]  wr_v;
    logic [31:0] wr_d [2];
    logic        cwr_rdy;

    logic        dma_read_request_ready, xcel_read_request_ready;
    logic [31:0] dma_read_data, xcel_read_data;
    logic        dma_read_data_valid, xcel_read_data_valid;
    logic        dma_write_request_ready, xcel_write_request_ready;
    logic        dma_write_data_ready, xcel_write_data_ready;
    logic        core_read_request_valid, core_write_request_valid;
    logic [31:0] core_read_addr, core_write_addr, core_read_len, core_write_len;
    logic [2:0]  core_read_size, core_write_size;
    logic [1:0]  core_read_burst, core_write_burst;
    logic        core_read_data_ready;
    logic [31:0] core_write_data;
    logic        core_write_data_valid;

    ddr_rr_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .xcel_busy(xcel_busy),
        .dma_read_request_valid(rqv[0][0]), .dma_read_request_ready(dma_read_request_ready),
        .dma_read_addr(rqa[0][0]), .dma_read_len(rql[0][0]), .dma_read_size(rqs[0][0]), .dma_read_burst(rqb[0][0]),
        .dma_read_data(dma_read_data), .dma_read_data_valid(dma_read_data_valid), .dma_read_data_ready(rd_rdy[0]),
        .xcel_read_request_valid(rqv[0][1]), .xcel_read_request_ready(xcel_read_request_ready),
        .xcel_read_addr(rqa[0][1]), .xcel_read_len(rql[0][1]), .xcel_read_size(rqs[0][1]), .xcel_read_burst(rqb[0][1]),
        .xcel_read_data(xcel_read_data), .xcel_read_data_valid(xcel_read_data_valid), .xcel_read_data_ready(rd_rdy[1]),
        .dma_write_request_valid(rqv[1][0]), .dma_write_request_ready(dma_write_request_ready),
        .dma_write_addr(rqa[1][0]), .dma_write_len(rql[1][0]), .dma_write_size(rqs[1][0]), .dma_write_burst(rqb[1][0]),
        .dma_write_data(wr_d[0]), .dma_write_data_valid(wr_v[0]), .dma_write_data_ready(dma_write_data_ready),
        .xcel_write_request_valid(rqv[1][1]), .xcel_write_request_ready(xcel_write_request_ready),
        .xcel_write_addr(rqa[1][1]), .xcel_write_len(rql[1][1]), .xcel_write_size(rqs[1][1]), .xcel_write_burst(rqb[1][1]),
        .xcel_write_data(wr_d[1]), .xcel_write_data_valid(wr_v[1]), .xcel_write_data_ready(xcel_write_data_ready),
        .core_read_request_valid(core_read_request_valid), .core_read_request_ready(crq_rdy[0]),
        .core_read_addr(core_read_addr), .core_read_len(core_read_len), .core_read_size(core_read_size),
        .core_read_burst(core_read_burst), .core_read_data(crd_d), .core_read_data_valid(crd_v),
        .core_read_data_ready(core_read_data_ready),
        .core_write_request_valid(core_write_request_valid), .core_write_request_ready(crq_rdy[1]),
        .core_write_addr(core_write_addr), .core_write_len(core_write_len), .core_write_size(core_write_size),
        .core_write_burst(core_write_burst), .core_write_data(core_write_data),
        .core_write_data_valid(core_write_data_valid), .core_write_data_ready(cwr_rdy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] ra [2][2][16];
    logic [31:0] rl [2][2][16];
    int head [2][2];
    int tail [2][2];
    int exp_w [2][64];
    int ew_head [2];
    int ew_tail [2];
    bit pref [2];
    int act [2];
    longint left [2];
    longint got [2][2];
    longint want [2][2];
    int beats;
    int stall_cnt;
    bit hold_rdy = 1'b0;
    bit overlap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rq_rdy(int c, int r);
        case ({c[0], r[0]})
            2'b00: return dma_read_request_ready;
            2'b01: return xcel_read_request_ready;
            2'b10: return dma_write_request_ready;
            default: return xcel_write_request_ready;
        endcase
    endfunction

    function automatic logic [63:0] core_f(int c, int f);
        case (f)
            0: return c == 0 ? 64'(core_read_request_valid) : 64'(core_write_request_valid);
            1: return c == 0 ? 64'(core_read_addr) : 64'(core_write_addr);
            2: return c == 0 ? 64'(core_read_len) : 64'(core_write_len);
            3: return c == 0 ? 64'(core_read_size) : 64'(core_write_size);
            default: return c == 0 ? 64'(core_read_burst) : 64'(core_write_burst);
        endcase
    endfunction

    task automatic chk_zero(input string tag);
        chk(tag, {dma_read_request_ready, xcel_read_request_ready, dma_read_data_valid, xcel_read_data_valid,
                  dma_write_request_ready, xcel_write_request_ready, dma_write_data_ready, xcel_write_data_ready,
                  core_read_request_valid, core_read_data_ready, core_write_request_valid, core_write_data_valid}, 0);
    endtask

    task automatic quiesce();
        rqv[0] = 2'b00; rqv[1] = 2'b00; crq_rdy = 2'b00; rd_rdy = 2'b00;
        crd_v = 1'b0; wr_v = 2'b00; cwr_rdy = 1'b0;
    endtask

    task automatic clear();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 2; r++) begin
                head[c][r] = 0; tail[c][r] = 0; got[c][r] = 0; want[c][r] = 0;
            end
            ew_head[c] = 0; ew_tail[c] = 0; act[c] = -1;
        end
    endtask

    task automatic add_req(input int c, input int r, input logic [31:0] a, input logic [31:0] l);
        ra[c][r][tail[c][r]] = a;
        rl[c][r][tail[c][r]] = l;
        tail[c][r]++;
        want[c][r] += longint'(l) + 1;
    endtask

    // Expected grant sequence from the arbitration rules applied to the pending request counts.
    task automatic plan();
        for (int c = 0; c < 2; c++) begin
            int p [2];
            p[0] = tail[c][0] - head[c][0];
            p[1] = tail[c][1] - head[c][1];
            while (p[0] + p[1] > 0) begin
                int w;
                w = (p[0] > 0 && p[1] > 0) ? (xcel_busy ? 1 : int'(pref[c])) : (p[1] > 0 ? 1 : 0);
                exp_w[c][ew_tail[c]] = w;
                ew_tail[c]++;
                pref[c] = (w == 0);
                p[w]--;
            end
        end
    endtask

    task automatic drive();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 2; r++) begin
                rqv[c][r] = head[c][r] < tail[c][r];
                rqa[c][r] = rqv[c][r] ? ra[c][r][head[c][r]] : 32'h0;
                rql[c][r] = rqv[c][r] ? rl[c][r][head[c][r]] : 32'h0;
            end
            crq_rdy[c] = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        for (int r = 0; r < 2; r++) begin
            rd_rdy[r] = $urandom_range(0, 3) != 0;
            wr_v[r]   = $urandom_range(0, 2) != 0;
            wr_d[r]   = $urandom;
        end
        crd_v   = $urandom_range(0, 3) != 0;
        crd_d   = $urandom;
        cwr_rdy = $urandom_range(0, 3) != 0;
        if (stall_cnt > 0) begin
            crd_v = 1'b0;
            cwr_rdy = 1'b0;
            stall_cnt--;
        end
    endtask

    task automatic sample();
        for (int c = 0; c < 2; c++) begin
            int a;
            bit fire;
            a = act[c];
            if (c == 0) begin
                chk("rd_valid_dma", dma_read_data_valid, (a == 0) ? crd_v : 1'b0);
                chk("rd_valid_xcel", xcel_read_data_valid, (a == 1) ? crd_v : 1'b0);
                if (a == 0 && crd_v) chk("rd_data_dma", dma_read_data, crd_d);
                if (a == 1 && crd_v) chk("rd_data_xcel", xcel_read_data, crd_d);
                chk("core_rd_ready", core_read_data_ready, (a >= 0) ? rd_rdy[a] : 1'b0);
                fire = a >= 0 && crd_v && rd_rdy[a];
            end else begin
                chk("wr_ready_dma", dma_write_data_ready, (a == 0) ? cwr_rdy : 1'b0);
                chk("wr_ready_xcel", xcel_write_data_ready, (a == 1) ? cwr_rdy : 1'b0);
                chk("core_wr_valid", core_write_data_valid, (a >= 0) ? wr_v[a] : 1'b0);
                if (a >= 0 && wr_v[a]) chk("core_wr_data", core_write_data, wr_d[a]);
                fire = a >= 0 && wr_v[a] && cwr_rdy;
            end
            if (fire) begin
                got[c][a]++;
                beats++;
                left[c]--;
                if (left[c] == 0) act[c] = -1;
            end
            if (a >= 0) begin
                chk("req_ready_in_data", {rq_rdy(c, 0), rq_rdy(c, 1)}, 2'b00);
                chk("core_req_in_data", core_f(c, 0), 0);
            end else begin
                for (int r = 0; r < 2; r++)
                    if (!(ew_head[c] < ew_tail[c] && exp_w[c][ew_head[c]] == r))
                        chk("req_ready_loser", rq_rdy(c, r), 0);
                if (core_f(c, 0) == 1 && crq_rdy[c]) begin
                    chk("grant_expected", ew_head[c] < ew_tail[c], 1);
                    if (ew_head[c] < ew_tail[c]) begin
                        int w;
                        w = exp_w[c][ew_head[c]];
                        ew_head[c]++;
                        chk("grant_who", rq_rdy(c, w), 1);
                        chk("core_addr", core_f(c, 1), ra[c][w][head[c][w]]);
                        chk("core_len", core_f(c, 2), rl[c][w][head[c][w]]);
                        chk("core_size", core_f(c, 3), w ? 3'd3 : 3'd2);
                        chk("core_burst", core_f(c, 4), w ? 2'b10 : 2'b01);
                        act[c] = w;
                        left[c] = longint'(rl[c][w][head[c][w]]) + 1;
                        head[c][w]++;
                    end
                end
            end
        end
    endtask

    task automatic run(input int budget, input int rst_beat, input int stall_beat);
        int cyc;
        bit done;
        bit stalled;
        cyc = 0; beats = 0; stall_cnt = 0; stalled = 1'b0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            #1;
            if (stall_beat >= 0 && !stalled && beats >= stall_beat) begin
                stall_cnt = 10;
                stalled = 1'b1;
            end
            drive();
            #1;
            sample();
            if (act[0] >= 0 && act[1] >= 0) overlap = 1'b1;
            cyc++;
            if (rst_beat >= 0 && beats >= rst_beat) begin
                #1 resetn = 1'b0;
                #1 chk_zero("reset_mid_burst");
                clear();
                pref[0] = 1'b0;
                pref[1] = 1'b0;
                quiesce();
                return;
            end
            done = act[0] < 0 && act[1] < 0;
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 2; r++)
                    if (head[c][r] < tail[c][r]) done = 1'b0;
        end
        chk("scenario_done", done, 1);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 2; r++)
                chk($sformatf("beats_c%0d_r%0d", c, r), got[c][r], want[c][r]);
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #2 chk_zero("idle_after_release");
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 2; r++) begin
                rqs[c][r] = r ? 3'd3 : 3'd2;
                rqb[c][r] = r ? 2'b10 : 2'b01;
                rqa[c][r] = 32'h0;
                rql[c][r] = 32'h0;
            end
            wr_d[c] = 32'h0;
        end
        crd_d = 32'h0;
        quiesce();
        clear();
        pref[0] = 1'b0;
        pref[1] = 1'b0;
        #12 chk_zero("reset_state");
        release_reset();

        // dma read len=3: request reaches the core one cycle after valid
        clear();
        add_req(0, 0, 32'h1000, 32'd3);
        plan();
        hold_rdy = 1'b1;
        @(posedge clk); #1 drive(); #1;
        chk("idle_no_core_req", core_read_request_valid, 0);
        @(posedge clk); #1 drive(); #1;
        chk("req_valid_next_cycle", core_read_request_valid, 1);
        chk("req_addr_next_cycle", core_read_addr, 32'h1000);
        hold_rdy = 1'b0;
        run(200, -1, -1);

        // simultaneous writes, without and with xcel_busy
        clear();
        xcel_busy = 1'b0;
        add_req(1, 0, 32'h2000, 32'd2);
        add_req(1, 1, 32'h3000, 32'd1);
        plan();
        run(300, -1, -1);
        clear();
        xcel_busy = 1'b1;
        add_req(1, 0, 32'h2100, 32'd1);
        add_req(1, 1, 32'h3100, 32'd2);
        plan();
        run(300, -1, -1);
        xcel_busy = 1'b0;

        // both requesters streaming len=0 reads alternate
        clear();
        for (int k = 0; k < 4; k++) begin
            add_req(0, 0, 32'h4000 + k, 32'd0);
            add_req(0, 1, 32'h5000 + k, 32'd0);
        end
        plan();
        run(400, -1, -1);

        // concurrent write and read bursts
        clear();
        overlap = 1'b0;
        add_req(1, 0, 32'h6000, 32'd7);
        add_req(0, 1, 32'h7000, 32'd7);
        plan();
        run(400, -1, -1);
        chk("channels_overlap", overlap, 1);

        // reset mid-burst, then a fresh single-beat request
        clear();
        add_req(0, 0, 32'h8000, 32'd5);
        plan();
        run(200, 2, -1);
        release_reset();
        @(posedge clk);
        #2 chk_zero("idle_second_cycle");
        clear();
        add_req(0, 1, 32'h9000, 32'd0);
        plan();
        run(100, -1, -1);

        // core stalls 10 cycles mid-burst
        clear();
        add_req(1, 1, 32'hA000, 32'd6);
        add_req(0, 0, 32'hB000, 32'd4);
        plan();
        run(400, -1, 3);

        // maximal len keeps streaming past any early wrap point
        clear();
        add_req(1, 0, 32'hC000, 32'hFFFF_FFFF);
        plan();
        run(300, 40, -1);
        release_reset();

        for (int it = 0; it < 3; it++) begin
            clear();
            xcel_busy = $urandom_range(0, 1) == 1;
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 2; r++)
                    for (int k = $urandom_range(0, 2); k > 0; k--)
                        add_req(c, r, $urandom, $urandom_range(0, 4));
            plan();
            run(600, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
